mem_responder: RTL
==================

# mem_responder

Memory-side responder for the LC-3 CPU's MAR/MDR memory port. It accepts single-word read and write requests, serves them either from external asynchronous SRAM with a fixed number of wait states or from the memory-mapped I/O word at 0xFFFF (switches on read, hex-display register on write), and returns read data on Data_to_CPU with a one-cycle ready pulse. It sits between the CPU datapath's MAR/MDR registers and the board SRAM and I/O pins.

## Interface
- WAIT_STATES, 2, SRAM access cycles per read or write; legal range 1..15
- IO_ADDR, 16'hFFFF, address decoded as memory-mapped I/O instead of SRAM
- Clk  in  1  system clock; all state changes on the rising edge
- Reset  in  1  reset; one clock; reset is asynchronous and active-high
- MEM_REQ  in  1  request strobe; level, held by the CPU until MEM_RDY
- MEM_WE  in  1  1 = write, 0 = read; sampled with MEM_REQ
- MAR  in  16  request address
- MDR  in  16  write data
- Data_to_CPU  out  16  read data; valid while MEM_RDY = 1 and held until the next read completes
- MEM_RDY  out  1  one-cycle completion pulse
- Switches  in  16  I/O read source
- hex_reg  out  16  I/O write target, drives the hex displays
- sram_addr  out  16  SRAM address
- sram_dq_in  in  16  SRAM read data
- sram_dq_out  out  16  SRAM write data
- sram_dq_oe  out  1  tristate enable for sram_dq_out at the pad
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE.
- IDLE: all SRAM strobes are high and sram_dq_oe = 0. When MEM_REQ = 1, the block captures MAR, MDR and MEM_WE into internal address, data and direction registers. Later changes on MAR, MDR or MEM_WE are ignored until the block returns to IDLE.
  - Captured address = IO_ADDR, read: Data_to_CPU <= Switches at the same edge; next state RD_DONE.
  - Captured address = IO_ADDR, write: hex_reg <= MDR at the same edge; next state WR_DONE. The SRAM is not touched.
  - Other addresses: the wait counter loads WAIT_STATES-1; next state is RD_WAIT or WR_WAIT according to MEM_WE.
- RD_WAIT: sram_ce_n = 0, sram_oe_n = 0, and sram_addr = captured address. The counter decrements each cycle. On the cycle the counter = 0, Data_to_CPU <= sram_dq_in and the next state is RD_DONE.
- WR_WAIT: sram_ce_n = 0, sram_we_n = 0, sram_dq_oe = 1, and sram_dq_out = captured data. When the counter reaches 0, the next state is WR_DONE.
- RD_DONE / WR_DONE: MEM_RDY = 1, all strobes are high, and sram_dq_oe = 0. The next state is always IDLE.
- The CPU drops MEM_REQ on the edge where it samples MEM_RDY = 1. If MEM_REQ is still 1 in IDLE, it is treated as a new request. Back-to-back requests are legal with no idle gap beyond the IDLE cycle.
- sram_addr and sram_dq_out hold their last captured values in IDLE.

## Timing
- Reset values: state IDLE; Data_to_CPU = 0; hex_reg = 0; MEM_RDY = 0; sram_ce_n, sram_oe_n and sram_we_n = 1; sram_dq_oe = 0; sram_addr = 0; sram_dq_out = 0; counter = 0.
- Reset asserted mid-transaction aborts it immediately and asynchronously: strobes go high and no MEM_RDY pulse is issued. A partial SRAM write is acceptable.
- SRAM latency: MEM_REQ is sampled at edge 0. RD_WAIT or WR_WAIT occupies cycles 1..WAIT_STATES, and MEM_RDY is high during cycle WAIT_STATES+1.
- I/O latency: MEM_RDY is high during cycle 1.
- Total occupancy per request: WAIT_STATES+2 cycles for SRAM and 2 cycles for I/O, each including the IDLE cycle.
- sram_we_n is low for exactly WAIT_STATES cycles. Address and data are stable for the whole low period and one cycle beyond it, since DONE holds the values.

## Structure
- Package mem_resp_pkg holds the state enum (mem_state_t) and the default constants IO_ADDR_DEF = 16'hFFFF and WAIT_STATES_DEF = 2.
- Sub-module mem_wait_ctr holds the 4-bit down-counter, with load, decrement and zero flag. The FSM and the capture registers stay in mem_responder.

## Test plan
- Reset, then read 0x0010 with the SRAM model returning 0x1234 and WAIT_STATES = 2 -> sram_oe_n low during cycles 1-2, MEM_RDY in cycle 3, Data_to_CPU = 0x1234.
- Write 0xBEEF to 0x0020 -> sram_we_n low for exactly 2 cycles with sram_dq_out = 0xBEEF and sram_dq_oe = 1; MEM_RDY in cycle 3; a later read of 0x0020 returns 0xBEEF.
- Read 0xFFFF with Switches = 0x00A5 -> MEM_RDY in cycle 1, Data_to_CPU = 0x00A5, and all SRAM strobes stay high.
- Write 0x0C3D to 0xFFFF -> hex_reg = 0x0C3D after edge 0, MEM_RDY in cycle 1, and no SRAM strobe activity.
- Change MAR and MDR during WR_WAIT, and issue a back-to-back request with MEM_REQ held high -> the first write uses the captured values; the second transaction starts from IDLE with the new values.
- Assert Reset in the middle of RD_WAIT -> strobes go high immediately, no MEM_RDY pulse, Data_to_CPU = 0, hex_reg = 0, and the next request completes normally.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and default constants for the LC-3 memory-side responder.
package mem_resp_pkg;

  localparam logic [15:0] IO_ADDR_DEF     = 16'hFFFF;
  localparam int unsigned WAIT_STATES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_DONE = 3'd3,
    ST_WR_DONE = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_wait_ctr.sv
// 4-bit SRAM wait-state down-counter with load, decrement and zero flag.
module mem_wait_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the LC-3 MAR/MDR port: serves SRAM with fixed wait
// states, or the memory-mapped I/O word (switches / hex display register).
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  output logic [15:0] Data_to_CPU,
  output logic        MEM_RDY,
  input  logic [15:0] Switches,
  output logic [15:0] hex_reg,
  output logic [15:0] sram_addr,
  input  logic [15:0] sram_dq_in,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [2:0]  dbg_state_o
);

  // Handshake: the CPU raises MEM_REQ (level) and holds it until it samples
  // MEM_RDY = 1 for one cycle; a request is accepted only in ST_IDLE, and
  // MAR/MDR/MEM_WE are captured on that edge and ignored afterwards.

  localparam logic [3:0] LOAD_VAL = 4'(WAIT_STATES - 1);

  mem_state_t  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        ctr_load, ctr_dec, ctr_zero;

  mem_wait_ctr u_wait_ctr (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (ctr_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    hex_d    = hex_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (MEM_REQ) begin
          addr_d  = MAR;
          wdata_d = MDR;
          if (MAR == IO_ADDR) begin
            // I/O word bypasses the SRAM entirely and completes next cycle.
            if (MEM_WE) begin
              hex_d   = MDR;
              state_d = ST_WR_DONE;
            end else begin
              rdata_d = Switches;
              state_d = ST_RD_DONE;
            end
          end else begin
            ctr_load = 1'b1;
            state_d  = MEM_WE ? ST_WR_WAIT : ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (ctr_zero) begin
          rdata_d = sram_dq_in;
          state_d = ST_RD_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_WR_WAIT: begin
        if (ctr_zero) begin
          state_d = ST_WR_DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      ST_RD_DONE, ST_WR_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      hex_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  // Strobes decode straight from the state so an async reset releases them at once.
  assign sram_ce_n   = !((state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT));
  assign sram_oe_n   = (state_q != ST_RD_WAIT);
  assign sram_we_n   = (state_q != ST_WR_WAIT);
  assign sram_dq_oe  = (state_q == ST_WR_WAIT);
  assign MEM_RDY     = (state_q == ST_RD_DONE) || (state_q == ST_WR_DONE);
  assign sram_addr   = addr_q;
  assign sram_dq_out = wdata_q;
  assign Data_to_CPU = rdata_q;
  assign hex_reg     = hex_q;
  assign dbg_state_o = state_q;

endmodule
